// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 sized-access data memory with req/ready handshake,
// configurable read latency, error reporting and a registered fetch port.
// Define DMEM_ERR_CNT_EN to add the saturating errCount output.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReq,
    input  logic        memWe,
    input  logic [2:0]  memFunct3,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    output logic        memReady,
    output logic        memRespValid,
    output logic [31:0] memReadData,
    output logic        memErr,
    input  logic [31:0] pcAddr,
    output logic [31:0] pcReadData
`ifdef DMEM_ERR_CNT_EN
    ,
    output logic [15:0] errCount
`endif
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, stateNext;
    logic [1:0] latCnt;
    logic [31:0] respData;
    logic respErr;
    logic [31:0] mem [DEPTH_WORDS];

    logic accept, memWrite;
    logic [32:0] memDiff, pcDiff;
    logic inRange, aligned, f3Legal, reqErr;
    logic [AW-1:0] wordIdx, pcIdx;
    logic pcOk;
    logic [31:0] rdShift, wrShift, loadVal;
    logic [3:0] byteEn;

    // Borrow in bit 32 flags an address below the base; never wraps.
    assign memDiff = {1'b0, memAddr} - {1'b0, BASE_ADDR};
    assign inRange = !memDiff[32] && ({1'b0, memDiff[31:0]} < SPAN);
    assign wordIdx = memDiff[AW+1:2];

    assign aligned = (memFunct3[1:0] == 2'd1) ? !memAddr[0] :
                     (memFunct3[1:0] == 2'd2) ? (memAddr[1:0] == 2'b00) :
                     1'b1;
    assign f3Legal = memWe ? (memFunct3 <= 3'd2) :
                     (memFunct3 != 3'd3 && memFunct3 < 3'd6);
    assign reqErr = !(inRange && aligned && f3Legal);

    assign rdShift = mem[wordIdx] >> {memAddr[1:0], 3'b000};
    assign wrShift = memWriteData << {memAddr[1:0], 3'b000};

    assign pcDiff = {1'b0, pcAddr} - {1'b0, BASE_ADDR};
    assign pcOk = !pcDiff[32] && ({1'b0, pcDiff[31:0]} < SPAN) &&
                  (pcAddr[1:0] == 2'b00);
    assign pcIdx = pcDiff[AW+1:2];

    // Lane select and sign/zero extension of the load result
    always_comb begin
        loadVal = 32'h0;
        case (memFunct3)
            3'd0: loadVal = {{24{rdShift[7]}}, rdShift[7:0]};
            3'd1: loadVal = {{16{rdShift[15]}}, rdShift[15:0]};
            3'd2: loadVal = rdShift;
            3'd4: loadVal = {24'h0, rdShift[7:0]};
            3'd5: loadVal = {16'h0, rdShift[15:0]};
            default: loadVal = 32'h0;
        endcase
    end

    // Byte enables for SB/SH/SW
    always_comb begin
        byteEn = 4'b0000;
        case (memFunct3)
            3'd0: byteEn = 4'b0001 << memAddr[1:0];
            3'd1: byteEn = 4'b0011 << {memAddr[1], 1'b0};
            3'd2: byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        stateNext = state;
        memReady = 1'b0;
        memRespValid = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE: begin
                memReady = 1'b1;
                if (memReq) begin
                    accept = 1'b1;
                    stateNext = (LAT_M1 == 2'd0) ? RESP : WAIT;
                end
            end
            WAIT: if (latCnt == 2'd1) stateNext = RESP;
            RESP: begin
                memRespValid = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign memWrite = accept && memWe && !reqErr && !rst;
    assign memReadData = respData;
    assign memErr = respErr && memRespValid;

    // State register, latency counter and captured response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            latCnt <= 2'd0;
            respData <= 32'h0;
            respErr <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                latCnt <= LAT_M1;
                respErr <= reqErr;
                respData <= (reqErr || memWe) ? 32'h0 : loadVal;
            end else if (state == WAIT) begin
                latCnt <= latCnt - 2'd1;
            end
        end
    end

    // Storage array write, committed on the accept edge only
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrShift[8*i +: 8];
            end
        end
    end

    // Fetch port: one-cycle registered read, old data on same-edge store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcReadData <= NOP;
        else pcReadData <= pcOk ? mem[pcIdx] : NOP;
    end

`ifdef DMEM_ERR_CNT_EN
    // Saturating count of error responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) errCount <= 16'h0;
        else if (memRespValid && memErr && errCount != 16'hFFFF)
            errCount <= errCount + 16'd1;
    end
`endif

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data memory for the RISC-V core. Successor to the fixed-size, single-word DataMem.
- Adds RV32 sized loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW), a req/ready/respValid handshake with configurable read latency, and alignment/range error reporting.
- Keeps a second registered instruction-fetch read port.
- Sits between the core's MEM stage and the word-addressed storage array.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 16.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-aligned.
- READ_LATENCY, 1: cycles from accept to respValid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- memReq  in  1  request valid
- memWe  in  1  1 = store, 0 = load
- memFunct3  in  3  RV32 funct3 size/sign code
- memAddr  in  32  byte address
- memWriteData  in  32  store data, right-aligned
- memReady  out  1  controller can accept a request
- memRespValid  out  1  one-cycle response pulse
- memReadData  out  32  load result, sign/zero-extended
- memErr  out  1  response is an error; qualified by memRespValid
- pcAddr  in  32  fetch byte address
- pcReadData  out  32  fetched word

Behaviour:
- Reset (async, rst=1): state IDLE; memReady=1; memRespValid=0; memErr=0; memReadData=0; pcReadData=32'h0000_0013 (NOP). Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: memReady=1. On memReq&memReady, capture request, load latency counter with READ_LATENCY-1, go to WAIT, or directly to RESP when READ_LATENCY=1.
  - WAIT: memReady=0; counter decrements each cycle; at 0 go to RESP.
  - RESP: memRespValid=1 for exactly one cycle, memReadData/memErr valid, return to IDLE. memReady=0 during RESP, so back-to-back throughput is one request per READ_LATENCY+1 cycles.
- Latency: response appears READ_LATENCY cycles after the accept edge.
- Store commit: on the accept edge only, via byte enables.
  - SB (f3=0): byte lane addr[1:0] <= wd[7:0].
  - SH (f3=1): lanes {addr[1],0}+{1,0} <= wd[15:0].
  - SW (f3=2): all lanes.
  - Store response: memReadData=0, memErr=0.
- Load data is read from the array on the accept edge and held through the latency pipeline.
  - LB=0 and LH=1 sign-extend; LW=2 full word; LBU=4 and LHU=5 zero-extend.
  - Lane is selected by addr[1:0].
- Error conditions (no array write; response is still delivered with memErr=1, memReadData=0):
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0;
  - out of range: addr<BASE_ADDR or addr-BASE_ADDR >= DEPTH_WORDS*4;
  - illegal funct3: load f3 in {3,6,7}, store f3 >3'd2.
- Address index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Index computation never wraps; out-of-range is always an error.
- memReq while memReady=0 is ignored, not queued. The requester must hold the request until it sees memReady.
- Fetch port: pcReadData <= word at pcAddr every cycle, 1-cycle latency, independent of the FSM.
  - Out-of-range or unaligned pcAddr returns 32'h0000_0013.
  - Same-word store and fetch in one cycle returns the old data (read-before-write).
- Reset mid-operation: pending response dropped, no memRespValid. A store already committed on its accept edge stays committed.

Optional Feature:
- Macro: DMEM_ERR_CNT_EN.
- Defined: adds output errCount (16 bits). It increments on each memRespValid&memErr, saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- READ_LATENCY=1: SW 32'hDEADBEEF @0x200, then LW @0x200 -> memRespValid 1 cycle after each accept; LW returns 32'hDEADBEEF, memErr=0.
- SB 8'h80 @0x201, then LB @0x201 / LBU @0x201 / LH @0x200 -> 32'hFFFFFF80 / 32'h00000080 / 32'hFFFF80EF.
- LW @0x202 and SH @0x203 -> memErr=1, readData=0, memory unchanged; with DMEM_ERR_CNT_EN, errCount=2.
- READ_LATENCY=3: LW accepted at cycle t -> memReady low t+1..t+3, memRespValid at t+3 only; memReq pulsed during WAIT is ignored.
- Assert rst during WAIT -> no memRespValid, memReady=1 and pcReadData=0x13 immediately; earlier stored data is preserved on a re-read.
- SW 32'h12345678 @0x10 with pcAddr=0x10 on the same edge -> pcReadData shows the old word, then 32'h12345678 next cycle.
